// File: rtl/vc_fifo_if.sv
// Handshake and status bundle between a producer/consumer (master) and vc_fifo (slave).
interface vc_fifo_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_enable;
    logic [4:0]            low_thr;
    logic [4:0]            high_thr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  error;

    modport master (
        output wr_enable, data_in, rd_enable, low_thr, high_thr,
        input  data_out, valid_out, count, empty, full,
               almost_empty, almost_full, error
    );

    modport slave (
        input  wr_enable, data_in, rd_enable, low_thr, high_thr,
        output data_out, valid_out, count, empty, full,
               almost_empty, almost_full, error
    );
endinterface

// File: rtl/vc_fifo.sv
// Synchronous FIFO with registered read port, occupancy flags, programmable
// almost-empty/almost-full thresholds and a sticky overflow/underflow error.
module vc_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    vc_fifo_if.slave   bus
);
    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  validOut_q, validOut_d;
    logic                  error_q, error_d;
    logic                  isEmpty, isFull, wrAccept, rdAccept;

    // A write into a full FIFO is only legal when a read frees a slot on the same edge.
    always_comb begin
        isEmpty    = (count_q == '0);
        isFull     = (count_q == FULL_CNT);
        rdAccept   = bus.rd_enable && !isEmpty;
        wrAccept   = bus.wr_enable && (!isFull || bus.rd_enable);

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        dataOut_d  = dataOut_q;
        validOut_d = 1'b0;
        error_d    = error_q;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
        end
        if (rdAccept) begin
            rdPtr_d    = rdPtr_q + ADDR_WIDTH'(1);
            dataOut_d  = mem[rdPtr_q];
            validOut_d = 1'b1;
        end
        if (wrAccept && !rdAccept) begin
            count_d = count_q + CNT_W'(1);
        end else if (rdAccept && !wrAccept) begin
            count_d = count_q - CNT_W'(1);
        end
        if ((bus.rd_enable && isEmpty) || (bus.wr_enable && isFull && !bus.rd_enable)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            error_q    <= error_d;
        end
    end

    // Storage is deliberately left out of reset; the cleared pointers make old words unreachable.
    always_ff @(posedge clk) begin
        if (!reset && wrAccept) begin
            mem[wrPtr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = dataOut_q;
    assign bus.valid_out    = validOut_q;
    assign bus.count        = count_q;
    assign bus.empty        = isEmpty;
    assign bus.full         = isFull;
    assign bus.almost_empty = 32'(count_q) <= 32'(bus.low_thr);
    assign bus.almost_full  = 32'(count_q) >= 32'(bus.high_thr);
    assign bus.error        = error_q;
endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vc_fifo;
    localparam int DW = 6;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   totalChecks = 0;
    int   passedChecks = 0;
    bit   checking = 1'b0;

    vc_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    vc_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain queue of stored words plus error/output state.
    int modelQ[$];
    int modelDout = 0;
    bit modelValid = 1'b0;
    bit modelErr = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelQ.delete();
            modelDout  = 0;
            modelValid = 1'b0;
            modelErr   = 1'b0;
        end else begin
            int  size;
            bit  we, re, wacc, racc;
            size = modelQ.size();
            we   = bus.wr_enable;
            re   = bus.rd_enable;
            wacc = we && (size < DEPTH || (re && size == DEPTH));
            racc = re && size > 0;
            if (re && size == 0) modelErr = 1'b1;
            if (we && size == DEPTH && !re) modelErr = 1'b1;
            if (racc) begin
                modelDout  = modelQ.pop_front();
                modelValid = 1'b1;
            end else begin
                modelValid = 1'b0;
            end
            if (wacc) modelQ.push_back(int'(bus.data_in));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual == expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            int size;
            size = modelQ.size();
            checkOutput("cmp_count",     int'(bus.count),        size);
            checkOutput("cmp_empty",     int'(bus.empty),        int'(size == 0));
            checkOutput("cmp_full",      int'(bus.full),         int'(size == DEPTH));
            checkOutput("cmp_aempty",    int'(bus.almost_empty), int'(size <= int'(bus.low_thr)));
            checkOutput("cmp_afull",     int'(bus.almost_full),  int'(size >= int'(bus.high_thr)));
            checkOutput("cmp_error",     int'(bus.error),        int'(modelErr));
            checkOutput("cmp_valid",     int'(bus.valid_out),    int'(modelValid));
            checkOutput("cmp_data_out",  int'(bus.data_out),     modelDout);
        end
    end

    // Inputs change 2 time units after a rising edge and are sampled on the next one.
    task automatic applyStimulus(input bit we, input int din, input bit re);
        bus.wr_enable = we;
        bus.data_in   = DW'(din);
        bus.rd_enable = re;
        @(posedge clk);
        #2;
    endtask

    task automatic resetPulse();
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        bus.data_in   = '0;
        bus.low_thr   = 5'd2;
        bus.high_thr  = 5'd14;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        checking = 1'b1;

        checkOutput("rst_count",  int'(bus.count), 0);
        checkOutput("rst_empty",  int'(bus.empty), 1);
        checkOutput("rst_full",   int'(bus.full), 0);
        checkOutput("rst_aempty", int'(bus.almost_empty), 1);
        checkOutput("rst_afull",  int'(bus.almost_full), 0);
        checkOutput("rst_error",  int'(bus.error), 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, i, 1'b0);
            checkOutput("fill_count", int'(bus.count), i + 1);
            checkOutput("fill_afull", int'(bus.almost_full), int'(i + 1 >= 14));
        end
        checkOutput("fill_full",  int'(bus.full), 1);
        checkOutput("fill_error", int'(bus.error), 0);

        applyStimulus(1'b1, 63, 1'b0);
        checkOutput("ovf_count", int'(bus.count), 16);
        checkOutput("ovf_error", int'(bus.error), 1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 0, 1'b1);
            checkOutput("drain_data",  int'(bus.data_out), i);
            checkOutput("drain_valid", int'(bus.valid_out), 1);
        end
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("idle_valid", int'(bus.valid_out), 0);
        checkOutput("idle_hold",  int'(bus.data_out), 15);
        checkOutput("idle_empty", int'(bus.empty), 1);

        resetPulse();
        checkOutput("clr_error", int'(bus.error), 0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("udf_valid", int'(bus.valid_out), 0);
        checkOutput("udf_count", int'(bus.count), 0);
        checkOutput("udf_error", int'(bus.error), 1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("udf_sticky", int'(bus.error), 1);
        resetPulse();
        checkOutput("udf_cleared", int'(bus.error), 0);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 20 + i, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 40 + i, 1'b1);
            checkOutput("rw_data",  int'(bus.data_out), (i < 16) ? 20 + i : 40 + i - 16);
            checkOutput("rw_count", int'(bus.count), 16);
        end
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("rw_error", int'(bus.error), 0);

        bus.high_thr = 5'd20;
        #1 checkOutput("hthr_above", int'(bus.almost_full), 0);
        bus.high_thr = 5'd16;
        #1 checkOutput("hthr_equal", int'(bus.almost_full), 1);
        bus.high_thr = 5'd14;

        resetPulse();
        bus.high_thr = 5'd0;
        #1 checkOutput("hthr_zero", int'(bus.almost_full), 1);
        bus.high_thr = 5'd14;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 7 * i, 1'b0);
        for (int t = 0; t <= 4; t++) begin
            bus.low_thr = 5'(t);
            #1 checkOutput("lthr_sweep", int'(bus.almost_empty), int'(t >= 3));
        end
        bus.low_thr = 5'd31;
        #1 checkOutput("lthr_max", int'(bus.almost_empty), 1);
        bus.low_thr = 5'd2;

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 50 + i, 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("pre_rst_count", int'(bus.count), 7);
        checkOutput("pre_rst_valid", int'(bus.valid_out), 1);
        bus.rd_enable = 1'b0;
        #1 reset = 1'b1;
        #1;
        checkOutput("async_count", int'(bus.count), 0);
        checkOutput("async_valid", int'(bus.valid_out), 0);
        checkOutput("async_empty", int'(bus.empty), 1);
        @(posedge clk);
        #2 reset = 1'b0;

        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("post_rst_valid", int'(bus.valid_out), 0);
        checkOutput("post_rst_error", int'(bus.error), 1);
        applyStimulus(1'b0, 0, 1'b0);
        @(negedge clk);
        checking = 1'b0;

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end
endmodule

// File: doc/vc_fifo.md
VC_FIFO -- requirements
Module: vc_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 6, SHALL set the width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set depth DEPTH = 2**ADDR_WIDTH = 16 words.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 wr_enable  input  1  SHALL request a write of data_in this cycle.
REQ-006 data_in  input  DATA_WIDTH  SHALL be the word to write.
REQ-007 rd_enable  input  1  SHALL request a read this cycle.
REQ-008 low_thr  input  5  SHALL be the almost-empty threshold, driven by the control FSM's *_l output.
REQ-009 high_thr  input  5  SHALL be the almost-full threshold, driven by the control FSM's *_h output.
REQ-010 data_out  output  DATA_WIDTH  SHALL carry the registered read word.
REQ-011 valid_out  output  1  SHALL mark data_out as valid for exactly one cycle per accepted read.
REQ-012 count  output  ADDR_WIDTH+1  SHALL report current occupancy, 0..DEPTH.
REQ-013 empty, full  output  1 each  SHALL flag occupancy 0 and DEPTH.
REQ-014 almost_empty, almost_full  output  1 each  SHALL flag threshold crossings.
REQ-015 error  output  1  SHALL flag a sticky overflow/underflow; feeds one bit of the FSM errors bus.

Function
REQ-016 Storage SHALL be a DEPTH-entry register array with ADDR_WIDTH-bit write and read pointers.
REQ-017 Write accepted when wr_enable=1 and (count<DEPTH, or rd_enable=1 with count=DEPTH); word stored at wr_ptr, wr_ptr increments.
REQ-018 Read accepted when rd_enable=1 and count>0; mem[rd_ptr] registered onto data_out, rd_ptr increments.
REQ-019 Read latency SHALL be 1 cycle: data_out/valid_out update on the edge that accepts the read.
REQ-020 valid_out SHALL be 0 in any cycle following no accepted read; data_out SHALL hold its last value.
REQ-021 Pointers SHALL wrap modulo DEPTH (15 -> 0) with no other side effect.
REQ-022 count SHALL be +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 Full with simultaneous read+write: both accepted, count stays DEPTH, no error.
REQ-024 Empty with simultaneous read+write: write accepted, read rejected, count -> 1, error set.
REQ-025 Write with count=DEPTH and no read (overflow): word dropped, pointers/count unchanged, error set.
REQ-026 Read with count=0 (underflow): pointers/count/data_out unchanged, valid_out=0, error set.
REQ-027 error SHALL remain 1 once set until reset.
REQ-028 empty = (count==0); full = (count==DEPTH); combinational from count.
REQ-029 almost_empty = (count <= low_thr); almost_full = (count >= high_thr); unsigned compare, combinational.
REQ-030 Threshold changes SHALL take effect on the flags in the same cycle; no latching inside the block.
REQ-031 Threshold values above DEPTH SHALL be legal: high_thr>DEPTH never asserts almost_full; low_thr>=DEPTH always asserts almost_empty.

Reset
REQ-032 reset=1 SHALL immediately clear wr_ptr, rd_ptr, count, data_out, valid_out and error, independent of clk.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 During reset, wr_enable/rd_enable SHALL be ignored; after deassertion empty=1, full=0, almost_empty=1, almost_full=(high_thr==0).
REQ-035 Reset asserted mid-transfer SHALL discard all stored words; first read after release with no write is an underflow.

Verification
REQ-036 Reset, low_thr=2, high_thr=14, write 16 words 0..15 -> count 16, full=1, almost_full from count 14, error=0.
REQ-037 Full FIFO, write once more -> error=1, count=16; then read 16 -> data_out 0..15 in order, each valid_out one cycle after request.
REQ-038 Empty FIFO, rd_enable=1 -> valid_out=0, count=0, error=1; error stays 1 until reset pulse, then 0.
REQ-039 count=16, rd_enable=wr_enable=1 for 20 cycles -> count stays 16, pointers wrap, output order preserved, error=0.
REQ-040 count=3, sweep low_thr 0..4 -> almost_empty=0 for 0..2, 1 for 3..4, same cycle as change.
REQ-041 Assert reset asynchronously between edges with count=7 -> count=0, valid_out=0, empty=1 before next clk edge.
